sysid_boot_checker: RTL and testbench
=====================================

// Module: sysid_boot_checker
// PURPOSE
//  Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its output.
//  After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp).
//  It compares both words against the values baked in at generation time.
//  Results go out as registered status flags, which gate boot and drive a board LED.
//  It keeps software from running against a mismatched FPGA image.
// PARAMETERS
//  EXPECTED_ID      32'h0000_0000  value required at word 0
//  EXPECTED_TS      32'd1354715134 value required at word 1
//  TIMEOUT_CYCLES   255            max waitrequest-stall cycles per read; 0 = no timeout
//  AUTO_START       1              1 = run one check automatically after reset release
// PORTS
//  clock         in   1   single clock domain
//  reset_n       in   1   reset: synchronous and active-low
//  start         in   1   1-cycle pulse; begins a check when idle
//  av_address    out  1   word address to sysid slave (0=ID, 1=timestamp)
//  av_read       out  1   Avalon read strobe
//  av_waitrequest in  1   slave/fabric stall; read completes in a cycle where it is low
//  av_readdata   in   32  read data, valid in the completing cycle (zero-latency slave)
//  busy          out  1   check in progress
//  done          out  1   check finished; held until next start
//  id_match      out  1   captured ID == EXPECTED_ID
//  ts_match      out  1   captured timestamp == EXPECTED_TS
//  timeout       out  1   a read exceeded TIMEOUT_CYCLES; check aborted
//  id_value      out  32  last captured ID word
//  ts_value      out  32  last captured timestamp word
// BEHAVIOUR
//  - All outputs are registered.
//    Reset (reset_n=0 at a clock edge) forces state IDLE and clears all outputs and the stall counter to 0.
//  - Reset mid-read is legal: av_read drops at that edge, and the transaction is abandoned.
//  - FSM states: IDLE, RD_ID, RD_TS, FIN.
//    IDLE -> RD_ID on a start pulse, or on the first post-reset edge when AUTO_START=1.
//    On entering RD_ID, clear done, matches, timeout and the stall counter.
//    Set busy=1, av_read=1, av_address=0.
//    RD_ID, av_waitrequest=0: capture av_readdata into id_value.
//      Compute id_match and register it now; go to RD_TS with av_address=1 and av_read kept at 1.
//    RD_TS, av_waitrequest=0: capture ts_value and ts_match.
//      Go to FIN with av_read=0, busy=0 and done=1.
//    FIN -> IDLE on the next edge; done and the flags stay held.
//  - Address and read are held stable for the whole of a stalled read (Avalon rule).
//  - Latency: with no stalls, done rises 3 edges after the edge that accepted start.
//    This is 2 read cycles plus 1.
//  - Stall counter: increments once per cycle that av_read=1 and av_waitrequest=1.
//    It resets to 0 each time a read completes.
//    When it equals TIMEOUT_CYCLES while still stalled, go to FIN.
//    In that case av_read=0, timeout=1, done=1, and id_match/ts_match=0.
//    Words not captured keep the value 0.
//    The counter is 8+ bits wide, sized as clog2(TIMEOUT_CYCLES+1), and saturates (no wrap).
//  - start while busy=1 is ignored.
//    start in the same cycle as FIN is ignored.
//    start in IDLE with done=1 begins a fresh check.
//  - Comparisons are full 32-bit equality. No partial matching is done.
// TESTING
//  1. AUTO_START=1, slave returns 0 / 1354715134, waitrequest=0.
//     -> av_read is high 2 cycles at addr 0 then 1; done=1 on the 3rd edge after reset release; id_match=ts_match=1, timeout=0.
//  2. Slave returns ID 32'h0000_0001.
//     -> id_match=0, ts_match=1, id_value=1, done=1.
//  3. waitrequest high 10 cycles on the ID read.
//     -> address and read stay stable; capture happens on cycle 11; matches are correct; timeout=0.
//  4. waitrequest stuck high, TIMEOUT_CYCLES=255.
//     -> after 255 stall cycles av_read=0, timeout=1, done=1, both matches 0.
//  5. reset_n=0 during RD_TS, then start after release (AUTO_START=0).
//     -> outputs cleared at reset; the new check runs cleanly.
//     -> start pulses issued while busy produce no extra reads.

Source files
------------

// File: rtl/sysid_boot_checker_if.sv
// sysid_boot_checker_if: Avalon-MM read channel between the boot checker and the system-ID slave.
interface sysid_boot_checker_if;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  modport master(output av_address, av_read, input av_waitrequest, av_readdata);
  modport slave(input av_address, av_read, output av_waitrequest, av_readdata);
endinterface

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads system ID and build timestamp over Avalon-MM and flags image mismatches.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1354715134,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start_i,
  sysid_boot_checker_if.master        av,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        id_match_o,
  output logic                        ts_match_o,
  output logic                        timeout_o,
  output logic [31:0]                 id_value_o,
  output logic [31:0]                 ts_value_o
);
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_t;
  state_t state_q, state_d;
  logic req_q, armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic rd_q, rd_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
  logic idm_q, idm_d, tsm_q, tsm_d, to_q, to_d;
  logic [31:0] idv_q, idv_d, tsv_q, tsv_d;
  logic stall_to;
  assign cnt_inc  = cnt_q + 1'b1;
  assign stall_to = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));
  // start is registered before acting on it, so a pulse seen outside IDLE is simply dropped
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      armed_q <= AUTO_START;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idm_q   <= 1'b0;
      tsm_q   <= 1'b0;
      to_q    <= 1'b0;
      idv_q   <= '0;
      tsv_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= start_i && (state_q == IDLE);
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idm_q   <= idm_d;
      tsm_q   <= tsm_d;
      to_q    <= to_d;
      idv_q   <= idv_d;
      tsv_q   <= tsv_d;
    end
  end
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    idm_d   = idm_q;
    tsm_d   = tsm_q;
    to_d    = to_q;
    idv_d   = idv_q;
    tsv_d   = tsv_q;
    case (state_q)
      IDLE: if (req_q || armed_q) begin
        state_d = RD_ID;
        armed_d = 1'b0;
        {rd_d, addr_d, busy_d, done_d, idm_d, tsm_d, to_d} = 7'b1010000;
        cnt_d   = '0;
        idv_d   = '0;
        tsv_d   = '0;
      end
      RD_ID, RD_TS: if (!av.av_waitrequest) begin
        cnt_d = '0;
        if (state_q == RD_ID) begin
          idv_d   = av.av_readdata;
          idm_d   = av.av_readdata == EXPECTED_ID;
          addr_d  = 1'b1;
          state_d = RD_TS;
        end else begin
          tsv_d   = av.av_readdata;
          tsm_d   = av.av_readdata == EXPECTED_TS;
          {rd_d, busy_d, done_d} = 3'b001;
          state_d = FIN;
        end
      end else begin
        cnt_d = &cnt_q ? cnt_q : cnt_inc;
        if (stall_to) begin
          {rd_d, busy_d, done_d, to_d, idm_d, tsm_d} = 6'b001100;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign av.av_read    = rd_q;
  assign av.av_address = addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign id_match_o    = idm_q;
  assign ts_match_o    = tsm_q;
  assign timeout_o     = to_q;
  assign id_value_o    = idv_q;
  assign ts_value_o    = tsv_q;
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: table-driven scoreboard bench for sysid_boot_checker with a stallable sysid slave model.
module tb_sysid_boot_checker;
  localparam logic [31:0] TS = 32'd1354715134;
  typedef struct {
    logic [31:0] id, ts;
    int sid, sts;
    logic idm, tsm, to;
    logic [31:0] idv, tsv;
    int lat;
  } vec_t;
  logic clk = 0, rst_n = 0, start_a = 0, start_b = 0;
  logic [31:0] id_w = 0, ts_w = TS;
  int sid = 0, sts = 0, scnt = 0, reads = 0, checks = 0, failures = 0;
  logic mon_st, mon_a;
  logic busy_a, done_a, idm_a, tsm_a, to_a, busy_b, done_b, idm_b, tsm_b, to_b;
  logic [31:0] idv_a, tsv_a, idv_b, tsv_b;
  vec_t vecs[8];
  vec_t sb[$];
  vec_t e;
  int n;
  sysid_boot_checker_if ia(), ib();
  sysid_boot_checker dut_a (.clock(clk), .reset_n(rst_n), .start_i(start_a), .av(ia),
    .busy_o(busy_a), .done_o(done_a), .id_match_o(idm_a), .ts_match_o(tsm_a), .timeout_o(to_a),
    .id_value_o(idv_a), .ts_value_o(tsv_a));
  sysid_boot_checker #(.AUTO_START(1'b0)) dut_b (.clock(clk), .reset_n(rst_n), .start_i(start_b), .av(ib),
    .busy_o(busy_b), .done_o(done_b), .id_match_o(idm_b), .ts_match_o(tsm_b), .timeout_o(to_b),
    .id_value_o(idv_b), .ts_value_o(tsv_b));
  always #5 clk = ~clk;
  assign ia.av_waitrequest = 1'b0;
  assign ia.av_readdata    = ia.av_address ? ts_w : id_w;
  assign ib.av_readdata    = ib.av_address ? ts_w : id_w;
  assign ib.av_waitrequest = ib.av_read && (scnt < (ib.av_address ? sts : sid));
  always @(posedge clk) scnt <= (!ib.av_read || !ib.av_waitrequest) ? 0 : scnt + 1;
  always @(posedge clk) if (rst_n && ib.av_read && !ib.av_waitrequest) reads++;
  // a stalled read must keep read and address unchanged unless it was aborted by timeout
  always @(posedge clk) begin
    mon_st = rst_n && ib.av_read && ib.av_waitrequest;
    mon_a  = ib.av_address;
    #1;
    if (mon_st) begin
      checks++;
      if (!(to_b || (ib.av_read && ib.av_address == mon_a))) begin
        failures++;
        $display("FAIL stall_hold: read=%0b addr=%0b required read=1 addr=%0b", ib.av_read, ib.av_address, mon_a);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic pulse_b();
    start_b = 1;
    @(negedge clk);
    start_b = 0;
  endtask
  task automatic wait_done(output int cyc);
    @(negedge clk);
    cyc = 2;
    while (!done_b && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_done", {31'd0, done_b}, 32'd1);
  endtask
  initial begin
    vecs[0] = '{32'h0, TS, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0, TS, 4};
    vecs[1] = '{32'h1, TS, 0, 0, 1'b0, 1'b1, 1'b0, 32'h1, TS, 4};
    vecs[2] = '{32'h0, TS, 10, 0, 1'b1, 1'b1, 1'b0, 32'h0, TS, 14};
    vecs[3] = '{32'h0, TS + 1, 0, 3, 1'b1, 1'b0, 1'b0, 32'h0, TS + 1, 7};
    vecs[4] = '{32'hDEAD_BEEF, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 8};
    vecs[5] = '{32'h0, TS, 1000, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 257};
    vecs[6] = '{32'h1234, TS, 0, 1000, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 258};
    vecs[7] = '{32'h0, TS, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0, TS, 4};
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_b}, 0);
    chk("rst_done", {31'd0, done_b}, 0);
    chk("rst_read", {31'd0, ib.av_read}, 0);
    chk("rst_idv", idv_b, 0);
    chk("rst_a_read", {31'd0, ia.av_read}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("auto_e1_read", {30'd0, ia.av_read, ia.av_address}, 32'h2);
    chk("auto_e1_busy", {31'd0, busy_a}, 1);
    chk("auto_e1_done", {31'd0, done_a}, 0);
    @(negedge clk);
    chk("auto_e2_read", {30'd0, ia.av_read, ia.av_address}, 32'h3);
    chk("auto_e2_done", {31'd0, done_a}, 0);
    @(negedge clk);
    chk("auto_e3_done", {31'd0, done_a}, 1);
    chk("auto_e3_flags", {28'd0, ia.av_read, idm_a, tsm_a, to_a}, 32'h6);
    chk("auto_b_idle", {31'd0, busy_b}, 0);
    for (int i = 0; i < 8; i++) begin
      id_w = vecs[i].id;
      ts_w = vecs[i].ts;
      sid  = vecs[i].sid;
      sts  = vecs[i].sts;
      sb.push_back(vecs[i]);
      pulse_b();
      wait_done(n);
      e = sb.pop_front();
      chk($sformatf("v%0d_latency", i), n, e.lat);
      chk($sformatf("v%0d_flags", i), {28'd0, busy_b, idm_b, tsm_b, to_b}, {29'd0, e.idm, e.tsm, e.to});
      chk($sformatf("v%0d_idv", i), idv_b, e.idv);
      chk($sformatf("v%0d_tsv", i), tsv_b, e.tsv);
      chk($sformatf("v%0d_read", i), {31'd0, ib.av_read}, 0);
      @(negedge clk);
    end
    id_w = 0; ts_w = TS; sid = 0; sts = 20;
    pulse_b();
    n = 0;
    while (ib.av_address != 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_ts", {31'd0, ib.av_address}, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_read", {31'd0, ib.av_read}, 0);
    chk("mid_rst_flags", {27'd0, busy_b, done_b, idm_b, tsm_b, to_b}, 0);
    chk("mid_rst_idv", idv_b, 0);
    rst_n = 1;
    sts = 0;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, busy_b}, 0);
    reads = 0;
    pulse_b();
    @(negedge clk);
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    n = 0;
    while (!done_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_start_reads", reads, 2);
    chk("busy_start_flags", {28'd0, done_b, idm_b, tsm_b, to_b}, 32'hE);
    pulse_b();
    @(negedge clk);
    chk("fin_start_ignored", {29'd0, busy_b, ib.av_read, done_b}, 32'h1);
    chk("fin_start_reads", reads, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
